// File: rtl/cfg_pkg.sv
// Shared definitions for the configuration register bank: address map,
// STATUS bit positions and the transaction state encoding.
package cfg_pkg;

   localparam int unsigned CFG_ADDR_W = 8;
   localparam int unsigned CFG_DATA_W = 32;

   localparam logic [CFG_ADDR_W-1:0] CFG_ADDR_ID     = 8'h00;
   localparam logic [CFG_ADDR_W-1:0] CFG_ADDR_STATUS = 8'h01;
   localparam logic [CFG_ADDR_W-1:0] CFG_ADDR_CTRL0  = 8'h02;

   // STATUS register layout
   localparam int unsigned STS_BAD_ADDR = 0;
   localparam int unsigned STS_RO_WRITE = 1;
   localparam int unsigned STS_LIVE_LSB = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_ACK  = 2'd2
   } cfg_state_e;

endpackage

// File: rtl/sync_ff.sv
// Enable-level synchroniser: STAGES-deep flop chain, pass-through at depth 0.
// Ports: clock, reset (sync, active-high), d_i (async level), q_o (synchronised).
module sync_ff #(
   parameter int unsigned STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   if (STAGES == 0) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = clock ^ reset;
      assign q_o = d_i;
   end else begin : g_chain
      logic [STAGES-1:0] chain_q;

      always_ff @(posedge clock) begin
         if (reset) begin
            chain_q <= '0;
         end else begin
            chain_q[0] <= d_i;
            for (int i = 1; i < int'(STAGES); i++) begin
               chain_q[i] <= chain_q[i-1];
            end
         end
      end

      assign q_o = chain_q[STAGES-1];
   end

endmodule

// File: rtl/cfg_reg_bank.sv
// Configuration register slave on a command-socket module slot. Executes
// mread/mwrite requests against ID, STATUS and N_CTRL control registers and
// answers with a 4-phase level acknowledge.
// Ports:
//   clock, reset          block clock, synchronous active-high reset
//   cfg_mread_en/mwrite_en request levels from the master (may be async)
//   cfg_addr, cfg_data_mwrite  address / write data, held by the master
//   cfg_data_mread, cfg_sack   reply data and acknowledge level
//   status_i              live status mirrored into STATUS[31:16]
//   ctrl_o                flat control registers, reg k at [32k+31:32k]
//   wr_pulse_o            one-cycle strobe per control register on write
//   err_o                 OR of the sticky error bits
module cfg_reg_bank
   import cfg_pkg::*;
#(
   parameter logic [31:0] ID_WORD     = 32'h0000_0000,
   parameter int unsigned N_CTRL      = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    cfg_mread_en,
   input  logic                    cfg_mwrite_en,
   input  logic [CFG_ADDR_W-1:0]   cfg_addr,
   input  logic [CFG_DATA_W-1:0]   cfg_data_mwrite,
   output logic [CFG_DATA_W-1:0]   cfg_data_mread,
   output logic                    cfg_sack,
   input  logic [15:0]             status_i,
   output logic [32*N_CTRL-1:0]    ctrl_o,
   output logic [N_CTRL-1:0]       wr_pulse_o,
   output logic                    err_o
);

   localparam logic [CFG_ADDR_W-1:0] CTRL_SPAN = CFG_ADDR_W'(N_CTRL);

   logic rd_s;
   logic wr_s;

   sync_ff #(.STAGES(SYNC_STAGES)) u_sync_rd (
      .clock (clock),
      .reset (reset),
      .d_i   (cfg_mread_en),
      .q_o   (rd_s)
   );

   sync_ff #(.STAGES(SYNC_STAGES)) u_sync_wr (
      .clock (clock),
      .reset (reset),
      .d_i   (cfg_mwrite_en),
      .q_o   (wr_s)
   );

   cfg_state_e              state_q;
   logic [CFG_ADDR_W-1:0]   addr_q;
   logic [CFG_DATA_W-1:0]   wdata_q;
   logic                    is_wr_q;
   logic [CFG_DATA_W-1:0]   rdata_q, rdata_d;
   logic                    sack_q;
   logic [CFG_DATA_W-1:0]   ctrl_q [N_CTRL];
   logic [CFG_DATA_W-1:0]   ctrl_d [N_CTRL];
   logic [N_CTRL-1:0]       wr_pulse_q, wr_pulse_d;
   logic                    bad_q, bad_d;
   logic                    ro_q, ro_d;
   logic                    err_q;

   logic [CFG_ADDR_W-1:0]   ctrl_off;
   logic                    ctrl_hit;

   assign ctrl_off = addr_q - CFG_ADDR_CTRL0;
   assign ctrl_hit = (addr_q >= CFG_ADDR_CTRL0) && (ctrl_off < CTRL_SPAN);

   // Effect of the latched request; committed by the EXEC cycle only.
   always_comb begin
      ctrl_d     = ctrl_q;
      wr_pulse_d = '0;
      bad_d      = bad_q;
      ro_d       = ro_q;
      rdata_d    = '0;

      if (addr_q == CFG_ADDR_ID) begin
         if (is_wr_q) ro_d = 1'b1;
         rdata_d = ID_WORD;
      end else if (addr_q == CFG_ADDR_STATUS) begin
         if (is_wr_q) begin
            bad_d = bad_q & ~wdata_q[STS_BAD_ADDR];
            ro_d  = ro_q  & ~wdata_q[STS_RO_WRITE];
         end
         rdata_d[CFG_DATA_W-1:STS_LIVE_LSB] = status_i;
         rdata_d[STS_BAD_ADDR]              = bad_d;
         rdata_d[STS_RO_WRITE]              = ro_d;
      end else if (ctrl_hit) begin
         for (int k = 0; k < int'(N_CTRL); k++) begin
            if (ctrl_off == CFG_ADDR_W'(k)) begin
               if (is_wr_q) begin
                  ctrl_d[k]     = wdata_q;
                  wr_pulse_d[k] = 1'b1;
               end
               rdata_d = ctrl_d[k];
            end
         end
      end else begin
         bad_d = 1'b1;
      end
   end

   // Transaction sequencer: IDLE -> EXEC -> ACK, 4-phase release back to IDLE.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         is_wr_q    <= 1'b0;
         rdata_q    <= '0;
         sack_q     <= 1'b0;
         wr_pulse_q <= '0;
         bad_q      <= 1'b0;
         ro_q       <= 1'b0;
         err_q      <= 1'b0;
         for (int k = 0; k < int'(N_CTRL); k++) begin
            ctrl_q[k] <= '0;
         end
      end else begin
         wr_pulse_q <= '0;
         case (state_q)
            ST_IDLE: begin
               if (rd_s || wr_s) begin
                  addr_q  <= cfg_addr;
                  wdata_q <= cfg_data_mwrite;
                  // Simultaneous read and write requests resolve to a read.
                  is_wr_q <= wr_s & ~rd_s;
                  state_q <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               ctrl_q     <= ctrl_d;
               wr_pulse_q <= wr_pulse_d;
               bad_q      <= bad_d;
               ro_q       <= ro_d;
               err_q      <= bad_d | ro_d;
               rdata_q    <= rdata_d;
               sack_q     <= 1'b1;
               state_q    <= ST_ACK;
            end
            ST_ACK: begin
               if (!rd_s && !wr_s) begin
                  sack_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   for (genvar k = 0; k < int'(N_CTRL); k++) begin : g_ctrl_out
      assign ctrl_o[32*k +: 32] = ctrl_q[k];
   end

   assign cfg_data_mread = rdata_q;
   assign cfg_sack       = sack_q;
   assign wr_pulse_o     = wr_pulse_q;
   assign err_o          = err_q;

endmodule

// File: doc/cfg_reg_bank.md
# cfg_reg_bank

Configuration register slave that sits directly downstream of the command-socket master, on one of its six module slots. It receives mread/mwrite requests over the shared addr/data bus with a per-module enable, executes them against a small bank of ID, status and control registers, and returns readback data with a level acknowledge. Request enables are synchronised internally, so the bank may run in a clock domain different from the master's.

## Interface
- ID_WORD, 32'h0000_0000: constant returned at address 0x00.
- N_CTRL, 4: number of read/write control registers, 1..16.
- SYNC_STAGES, 2: synchroniser depth on the enable inputs. 0 means same clock domain.

- clock  in  1  block clock.
- reset  in  1  synchronous, active-high.
- cfg_mread_en  in  1  read request level from the master, held until cfg_sack.
- cfg_mwrite_en  in  1  write request level, held until cfg_sack.
- cfg_addr  in  8  register address; stable while either enable is high.
- cfg_data_mwrite  in  32  write data; stable while cfg_mwrite_en is high.
- cfg_data_mread  out  32  reply data; valid while cfg_sack is high.
- cfg_sack  out  1  slave acknowledge level.
- status_i  in  16  live status bits, mirrored into STATUS[31:16].
- ctrl_o  out  32*N_CTRL  flat control register bus; register k is at bits [32k+31:32k].
- wr_pulse_o  out  N_CTRL  one-cycle strobe per control register on a write.
- err_o  out  1  OR of the sticky error bits.

## Operation
- Address map:
  - 0x00 is ID, read-only (RO).
  - 0x01 is STATUS:
    - bit0 = bad_addr (sticky);
    - bit1 = ro_write (sticky);
    - bits[15:2] read 0;
    - bits[31:16] = status_i, sampled in EXEC.
    - Writing 1 to bit0 or bit1 clears that bit (write-1-to-clear).
  - 0x02 .. 0x02+N_CTRL-1 are control register k = addr-2, read/write.
  - Every other address is unmapped.
- States: IDLE, EXEC, ACK.
- IDLE: when the synchronised rd_s or wr_s is high, latch cfg_addr and cfg_data_mwrite, then go to EXEC. If rd_s and wr_s are both high, treat the request as a read; no register changes.
- EXEC (one cycle):
  - Write to a control register: ctrl[k] <= data; wr_pulse_o[k] = 1 for this cycle only.
  - Write to STATUS: clear the write-1-to-clear bits.
  - Write to ID: set ro_write; the ID value is unchanged.
  - Unmapped read or write: set bad_addr; reply is 32'h0.
  - Load cfg_data_mread with the post-operation value of the addressed register. A write therefore returns its readback.
  - Go to ACK with cfg_sack = 1.
- ACK: hold cfg_sack and cfg_data_mread. When rd_s and wr_s are both low, drop cfg_sack and go to IDLE. This is a 4-phase handshake.
- Sticky bits set in the same EXEC that clears them: the set wins.
- Reset mid-operation: go to IDLE; all outputs return to reset values. If an enable is still high after reset, the request is executed again.

## Timing
- Reset values: cfg_sack 0, cfg_data_mread 0, ctrl_o all 0, wr_pulse_o 0, sticky bits 0, err_o 0, state IDLE.
- Enable first sampled high at edge N:
  - state is EXEC after edge N+SYNC_STAGES;
  - cfg_sack, the ctrl_o update and wr_pulse_o all appear after edge N+SYNC_STAGES+1.
- Enable first sampled low at edge M (in ACK): cfg_sack is 0 after edge M+SYNC_STAGES.
- cfg_addr and cfg_data_mwrite are not synchronised. They are captured only once the synchronised enable is seen, and rely on the master holding them stable.
- err_o is registered and updates in the same cycle as the sticky bits.
- Throughput: one transaction per 2*(SYNC_STAGES+1)+1 cycles minimum.

## Structure
- Shared package cfg_pkg holds:
  - address constants CFG_ADDR_ID = 8'h00, CFG_ADDR_STATUS = 8'h01, CFG_ADDR_CTRL0 = 8'h02;
  - STATUS bit indices;
  - the state encoding.
- One sub-module, sync_ff: a parameterised SYNC_STAGES-deep flop chain, instantiated for each of the two enables. With depth 0 it is a pass-through.

## Test plan
- Read 0x00 with ID_WORD=32'hCAFE_0001 → cfg_sack rises after N+3, cfg_data_mread = 32'hCAFE_0001; cfg_sack falls 2 cycles after the enable drops.
- Write 0x03 with 32'h1234_5678 → ctrl_o[63:32] = 32'h1234_5678, wr_pulse_o = 4'b0010 for exactly one cycle, reply = 32'h1234_5678; a following read of 0x03 returns the same value.
- Write to 0x00, then read 0x41 → after the write STATUS[1] = 1; after the read STATUS[1:0] = 2'b11, the read reply is 0 and err_o = 1.
- Write 32'h1 to 0x01 → STATUS bit0 cleared, bit1 remains set, err_o stays 1. Then write 32'h2 → err_o = 0. With status_i = 16'hA5A5, reads of 0x01 return 32'hA5A5_0000.
- Raise both enables together, addressed at 0x02 with data 32'hFFFF_FFFF → handled as a read; ctrl_o unchanged, no wr_pulse_o.
- Assert reset while in ACK with cfg_mwrite_en still high → cfg_sack=0 and ctrl_o=0 after reset; the write then re-executes and cfg_sack rises again.
